// File: rtl/huff_cfg_ctrl.sv
// Huffman encoder-atom controller: streams a codebook into the atom's lookup table,
// then feeds symbols through the atom with a ready/valid handshake on both sides.
module huff_cfg_ctrl #(
    parameter int SYMBOL_WIDTH      = 4,
    parameter int ENC_MAX_WIDTH     = 4,
    parameter int ENC_MAX_LEN_WIDTH = 2,
    parameter int NUM_SYMBOLS       = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         cb_valid,
    output logic                         cb_ready,
    input  logic [ENC_MAX_WIDTH-1:0]     cb_enc,
    input  logic [ENC_MAX_LEN_WIDTH-1:0] cb_len,
    input  logic                         sym_valid,
    output logic                         sym_ready,
    input  logic [SYMBOL_WIDTH-1:0]      sym_in,
    output logic                         config_en,
    output logic [NUM_SYMBOLS-1:0]       config_select,
    output logic [ENC_MAX_WIDTH-1:0]     config_enc,
    output logic [ENC_MAX_LEN_WIDTH-1:0] config_enc_len,
    output logic [SYMBOL_WIDTH-1:0]      symbol,
    input  logic [ENC_MAX_WIDTH-1:0]     enc,
    input  logic [ENC_MAX_LEN_WIDTH-1:0] enc_len,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ENC_MAX_WIDTH-1:0]     out_enc,
    output logic [ENC_MAX_LEN_WIDTH-1:0] out_len,
    output logic                         loaded,
    output logic [15:0]                  sym_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    localparam logic [SYMBOL_WIDTH-1:0] LAST_IDX = SYMBOL_WIDTH'(NUM_SYMBOLS - 1);
    localparam logic [NUM_SYMBOLS-1:0]  SEL_ONE  = NUM_SYMBOLS'(1);

    state_t                       state_q, state_d;
    logic [SYMBOL_WIDTH-1:0]      idx_q, idx_d;
    logic                         pending_q, pending_d;
    logic                         loaded_q, loaded_d;
    logic                         config_en_q, config_en_d;
    logic [NUM_SYMBOLS-1:0]       config_select_q, config_select_d;
    logic [ENC_MAX_WIDTH-1:0]     config_enc_q, config_enc_d;
    logic [ENC_MAX_LEN_WIDTH-1:0] config_enc_len_q, config_enc_len_d;
    logic [SYMBOL_WIDTH-1:0]      symbol_q, symbol_d;
    logic                         out_valid_q, out_valid_d;
    logic [15:0]                  sym_count_q, sym_count_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latches are inferred.
        state_d          = state_q;
        idx_d            = idx_q;
        pending_d        = pending_q;
        loaded_d         = loaded_q;
        config_en_d      = 1'b0;
        config_select_d  = '0;
        config_enc_d     = config_enc_q;
        config_enc_len_d = config_enc_len_q;
        symbol_d         = symbol_q;
        out_valid_d      = out_valid_q;
        sym_count_d      = sym_count_q;
        cb_ready         = 1'b0;
        sym_ready        = 1'b0;

        if (out_valid_q && out_ready) begin
            sym_count_d = sym_count_q + 16'd1;
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end

            LOAD: begin
                cb_ready = 1'b1;
                if (cb_valid) begin
                    config_en_d      = 1'b1;
                    config_select_d  = SEL_ONE << idx_q;
                    config_enc_d     = cb_enc;
                    config_enc_len_d = cb_len;
                    idx_d            = idx_q + SYMBOL_WIDTH'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d     = RUN;
                        loaded_d    = 1'b1;
                        sym_count_d = '0;
                        idx_d       = '0;
                    end
                end
            end

            RUN: begin
                // A requested reload blocks new symbols until the last output has drained.
                sym_ready = !pending_q && (!out_valid_q || out_ready);
                if (start) begin
                    pending_d = 1'b1;
                end
                if (sym_valid && sym_ready) begin
                    symbol_d    = sym_in;
                    out_valid_d = 1'b1;
                end
                if (pending_q && !out_valid_q) begin
                    state_d   = LOAD;
                    loaded_d  = 1'b0;
                    pending_d = 1'b0;
                    idx_d     = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            pending_q        <= 1'b0;
            loaded_q         <= 1'b0;
            config_en_q      <= 1'b0;
            config_select_q  <= '0;
            config_enc_q     <= '0;
            config_enc_len_q <= '0;
            symbol_q         <= '0;
            out_valid_q      <= 1'b0;
            sym_count_q      <= '0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            pending_q        <= pending_d;
            loaded_q         <= loaded_d;
            config_en_q      <= config_en_d;
            config_select_q  <= config_select_d;
            config_enc_q     <= config_enc_d;
            config_enc_len_q <= config_enc_len_d;
            symbol_q         <= symbol_d;
            out_valid_q      <= out_valid_d;
            sym_count_q      <= sym_count_d;
        end
    end

    assign config_en      = config_en_q;
    assign config_select  = config_select_q;
    assign config_enc     = config_enc_q;
    assign config_enc_len = config_enc_len_q;
    assign symbol         = symbol_q;
    assign out_valid      = out_valid_q;
    assign loaded         = loaded_q;
    assign sym_count      = sym_count_q;
    assign out_enc        = enc;
    assign out_len        = enc_len;

endmodule

// File: tb/tb_huff_cfg_ctrl.sv
// Bench for huff_cfg_ctrl: models the encoder atom as a lookup table written by the
// controller, and checks loads and symbol streams against bench-side expectations.
module tb_huff_cfg_ctrl;

    localparam int SW = 4;
    localparam int EW = 4;
    localparam int LW = 2;
    localparam int NS = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          cb_valid;
    logic          cb_ready;
    logic [EW-1:0] cb_enc;
    logic [LW-1:0] cb_len;
    logic          sym_valid;
    logic          sym_ready;
    logic [SW-1:0] sym_in;
    logic          config_en;
    logic [NS-1:0] config_select;
    logic [EW-1:0] config_enc;
    logic [LW-1:0] config_enc_len;
    logic [SW-1:0] symbol;
    logic [EW-1:0] enc;
    logic [LW-1:0] enc_len;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] out_enc;
    logic [LW-1:0] out_len;
    logic          loaded;
    logic [15:0]   sym_count;

    huff_cfg_ctrl #(
        .SYMBOL_WIDTH(SW), .ENC_MAX_WIDTH(EW), .ENC_MAX_LEN_WIDTH(LW), .NUM_SYMBOLS(NS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cb_valid(cb_valid), .cb_ready(cb_ready), .cb_enc(cb_enc), .cb_len(cb_len),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_in(sym_in),
        .config_en(config_en), .config_select(config_select),
        .config_enc(config_enc), .config_enc_len(config_enc_len),
        .symbol(symbol), .enc(enc), .enc_len(enc_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_enc(out_enc), .out_len(out_len),
        .loaded(loaded), .sym_count(sym_count)
    );

    always #5 clk = ~clk;

    // Encoder atom: a table written through the config port, read combinationally.
    logic [EW-1:0] atom_enc [NS];
    logic [LW-1:0] atom_len [NS];
    always @(posedge clk) begin
        if (config_en) begin
            for (int j = 0; j < NS; j++) begin
                if (config_select[j]) begin
                    atom_enc[j] <= config_enc;
                    atom_len[j] <= config_enc_len;
                end
            end
        end
    end
    assign enc     = atom_enc[symbol];
    assign enc_len = atom_len[symbol];

    typedef struct {
        logic [SW-1:0] sym;
        logic [EW-1:0] exp_enc;
        logic [LW-1:0] exp_len;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int m_count  = 0;

    logic [EW-1:0] tbl_enc [NS];
    logic [LW-1:0] tbl_len [NS];
    logic [SW-1:0] sym_q [$];
    logic [EW-1:0] xenc_q [$];
    logic [LW-1:0] xlen_q [$];
    vec_t          vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic random_table();
        for (int i = 0; i < NS; i++) begin
            tbl_enc[i] = EW'($urandom);
            tbl_len[i] = LW'($urandom);
        end
    endtask

    task automatic push_random(input int n);
        logic [SW-1:0] s;
        for (int i = 0; i < n; i++) begin
            s = SW'($urandom_range(0, NS - 1));
            sym_q.push_back(s);
            xenc_q.push_back(tbl_enc[s]);
            xlen_q.push_back(tbl_len[s]);
        end
    endtask

    task automatic check_reset_state();
        sym_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst_config_en", config_en, 0);
        check("rst_config_select", config_select, 0);
        check("rst_config_enc", config_enc, 0);
        check("rst_config_enc_len", config_enc_len, 0);
        check("rst_symbol", symbol, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sym_count", sym_count, 0);
        check("rst_loaded", loaded, 0);
        check("rst_cb_ready", cb_ready, 0);
        check("rst_sym_ready", sym_ready, 0);
        sym_valid = 1'b0;
    endtask

    // Load n_entries of tbl_*; mode 0 = back-to-back, 1 = valid every other cycle,
    // 2 = random valid with random start pulses that must be ignored.
    task automatic do_load(input int mode, input int n_entries);
        int   k;
        int   cyc;
        logic vld;
        k   = 0;
        cyc = 0;
        while (k < n_entries && cyc < 400) begin
            case (mode)
                0:       vld = 1'b1;
                1:       vld = (cyc % 2 == 1);
                default: vld = 1'($urandom_range(0, 1));
            endcase
            cb_valid = vld;
            cb_enc   = tbl_enc[k];
            cb_len   = tbl_len[k];
            start    = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            check("load_cb_ready", cb_ready, 1);
            check("load_loaded_low", loaded, 0);
            check("load_sym_ready", sym_ready, 0);
            tick();
            check("load_config_en", config_en, vld);
            check("load_config_select", config_select, vld ? (32'd1 << k) : 32'd0);
            if (vld) begin
                check("load_config_enc", config_enc, tbl_enc[k]);
                check("load_config_enc_len", config_enc_len, tbl_len[k]);
                k++;
            end
            cyc++;
        end
        cb_valid = 1'b0;
        start    = 1'b0;
        check("load_entries", k, n_entries);
        if (n_entries == NS) begin
            check("loaded_after_last", loaded, 1);
            check("sym_count_cleared", sym_count, 0);
            check("run_cb_ready", cb_ready, 0);
            tick();
            check("config_en_single", config_en, 0);
            check("config_select_idle", config_select, 0);
            m_count = 0;
        end
    endtask

    // Stream everything queued in sym_q; mode 0 = always ready, 1 = random valid/ready,
    // 2 = out_ready low for cycles 2..4.
    task automatic run_stream(input int mode);
        int            cyc;
        logic          m_valid;
        logic [SW-1:0] m_sym;
        logic [EW-1:0] m_enc;
        logic [LW-1:0] m_len;
        logic          exp_ready;
        logic          fire;
        cyc     = 0;
        m_valid = 1'b0;
        m_sym   = '0;
        m_enc   = '0;
        m_len   = '0;
        while ((sym_q.size() > 0 || m_valid) && cyc < 2000) begin
            sym_valid = (sym_q.size() > 0) && (mode != 1 || $urandom_range(0, 3) != 0);
            sym_in    = '0;
            if (sym_q.size() > 0) sym_in = sym_q[0];
            case (mode)
                1:       out_ready = ($urandom_range(0, 2) != 0);
                2:       out_ready = !(cyc >= 2 && cyc <= 4);
                default: out_ready = 1'b1;
            endcase
            #1;
            exp_ready = !m_valid || out_ready;
            check("sym_ready", sym_ready, exp_ready);
            check("out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("symbol", symbol, m_sym);
                check("out_enc", out_enc, m_enc);
                check("out_len", out_len, m_len);
            end
            fire = m_valid && out_ready;
            if (fire) m_count++;
            if (sym_valid && exp_ready) begin
                m_sym   = sym_q.pop_front();
                m_enc   = xenc_q.pop_front();
                m_len   = xlen_q.pop_front();
                m_valid = 1'b1;
            end else if (fire) begin
                m_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        sym_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_drained", sym_q.size(), 0);
        check("stream_idle", m_valid, 0);
        check("sym_count", sym_count, m_count);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cb_valid  = 1'b0;
        cb_enc    = '0;
        cb_len    = '0;
        sym_valid = 1'b0;
        sym_in    = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        check_reset_state();
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_cb_ready", cb_ready, 0);
        check("idle_config_en", config_en, 0);

        // Codebook A: enc = i, len = i % 4, loaded back-to-back.
        for (int i = 0; i < NS; i++) begin
            tbl_enc[i] = EW'(i);
            tbl_len[i] = LW'(i % 4);
        end
        pulse_start();
        do_load(0, NS);

        // Vector table: symbols 0..15 then a few out-of-order picks, with expected codes.
        for (int i = 0; i < NS; i++) vecs[i] = '{SW'(i), EW'(i), LW'(i % 4)};
        vecs[16] = '{4'd15, 4'd15, 2'd3};
        vecs[17] = '{4'd0,  4'd0,  2'd0};
        vecs[18] = '{4'd7,  4'd7,  2'd3};
        vecs[19] = '{4'd10, 4'd10, 2'd2};
        for (int i = 0; i < NS; i++) begin
            sym_q.push_back(vecs[i].sym);
            xenc_q.push_back(vecs[i].exp_enc);
            xlen_q.push_back(vecs[i].exp_len);
        end
        run_stream(0);
        check("sym_count_16", sym_count, 16);
        for (int i = NS; i < 20; i++) begin
            sym_q.push_back(vecs[i].sym);
            xenc_q.push_back(vecs[i].exp_enc);
            xlen_q.push_back(vecs[i].exp_len);
        end
        run_stream(0);

        // Output stall for three cycles, then random handshakes.
        push_random(6);
        run_stream(2);
        push_random(40);
        run_stream(1);

        // Reload requested while one output is still waiting.
        sym_valid = 1'b1;
        sym_in    = 4'd5;
        out_ready = 1'b0;
        #1;
        check("pend_accept_ready", sym_ready, 1);
        tick();
        sym_valid = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("pend_cb_ready", cb_ready, 0);
            check("pend_sym_ready", sym_ready, 0);
            check("pend_out_valid", out_valid, 1);
            check("pend_loaded", loaded, 1);
            check("pend_out_enc", out_enc, tbl_enc[5]);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("pend_sym_ready_blocked", sym_ready, 0);
        tick();
        m_count++;
        check("pend_drained_count", sym_count, m_count);
        check("pend_out_valid_clr", out_valid, 0);
        check("pend_still_run", cb_ready, 0);
        tick();
        check("reload_cb_ready", cb_ready, 1);
        check("reload_loaded_low", loaded, 0);
        random_table();
        do_load(1, NS);
        push_random(30);
        run_stream(1);

        // Reset in the middle of a load, then a fresh load from entry 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        random_table();
        pulse_start();
        do_load(0, 7);
        rst_n = 1'b0;
        tick();
        check_reset_state();
        rst_n = 1'b1;
        tick();
        check("after_rst_idle", cb_ready, 0);
        random_table();
        pulse_start();
        do_load(2, NS);
        push_random(24);
        run_stream(1);

        // Reset with a symbol in flight drops it.
        sym_valid = 1'b1;
        sym_in    = 4'd3;
        out_ready = 1'b0;
        tick();
        sym_valid = 1'b0;
        check("inflight_out_valid", out_valid, 1);
        rst_n = 1'b0;
        tick();
        check_reset_state();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
